// File: rtl/rnn_pkg.sv
// rnn_pkg: shared state encoding and Q8.8 constants for the RNN step controller
package rnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_X,
        WAIT_X,
        ACC_X,
        START_H,
        WAIT_H,
        ACC_H,
        DONE
    } state_t;

    localparam int FRAC_BITS = 8;
    localparam logic signed [15:0] Q_ONE = 16'sd1 <<< FRAC_BITS;
    localparam logic signed [15:0] Q_NEG_ONE = -Q_ONE;

endpackage

// File: rtl/rnn_step_ctrl_if.sv
// rnn_step_ctrl_if: start/ready handshake and result read-out towards the matmul engine
interface rnn_step_ctrl_if #(
    parameter int HID_BITS = 2
) ();

    logic                mm_start;
    logic                mm_ready;
    logic                mm_src;
    logic [HID_BITS-1:0] mm_sel;
    logic [15:0]         mm_data;

    modport master (output mm_start, mm_src, mm_sel, input mm_ready, mm_data);
    modport slave  (input mm_start, mm_src, mm_sel, output mm_ready, mm_data);

endinterface

// File: rtl/q88_hardtanh.sv
// q88_hardtanh: clamps an 18-bit Q8.8 sum into the 16-bit range [-1.0, +1.0]
module q88_hardtanh
    import rnn_pkg::*;
(
    input  logic signed [17:0] din,
    output logic signed [15:0] dout
);

    localparam logic signed [17:0] HI = 18'(Q_ONE);
    localparam logic signed [17:0] LO = -HI;

    // Saturate above +1.0 and below -1.0, otherwise pass the low 16 bits
    always_comb begin
        dout = din > HI ? Q_ONE : din < LO ? Q_NEG_ONE : din[15:0];
    end

endmodule

// File: rtl/rnn_step_ctrl.sv
// rnn_step_ctrl: sequences input and hidden matmul passes, bias add and hardtanh for one RNN step
module rnn_step_ctrl
    import rnn_pkg::*;
#(
    parameter int VEC_BITS = 2,
    parameter int HID_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_start,
    input  logic                clear_h,
    output logic                busy,
    output logic                done,
    rnn_step_ctrl_if.master     mm,
    output logic [HID_BITS-1:0] bias_sel,
    input  logic [15:0]         bias_data,
    input  logic [VEC_BITS-1:0] h_rd_sel,
    output logic [15:0]         h_rd_data
);

    localparam int M = 1 << HID_BITS;

    state_t                        state, state_nx;
    logic [HID_BITS-1:0]           sel;
    logic [15:0]                   acc [M];
    logic [15:0]                   h [M];
    logic                          last;
    logic [17:0]                   sum;
    logic [15:0]                   h_new;
    logic [VEC_BITS+HID_BITS-1:0]  rd_ext;

    assign last     = &sel;
    assign sum      = {{2{acc[sel][15]}}, acc[sel]}
                    + {{2{mm.mm_data[15]}}, mm.mm_data}
                    + {{2{bias_data[15]}}, bias_data};
    assign rd_ext   = {{HID_BITS{1'b0}}, h_rd_sel};
    assign bias_sel = sel;
    assign mm.mm_sel = sel;

    q88_hardtanh u_act (
        .din  (sum),
        .dout (h_new)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs; mm_src tracks the H states so it stays stable through WAIT/ACC
    always_comb begin
        state_nx    = state;
        busy        = state != IDLE;
        done        = state == DONE;
        mm.mm_src   = state inside {START_H, WAIT_H, ACC_H};
        mm.mm_start = state inside {START_X, START_H} && mm.mm_ready;
        case (state)
            IDLE:    state_nx = !clear_h && step_start ? START_X : IDLE;
            START_X: state_nx = mm.mm_ready ? WAIT_X : START_X;
            WAIT_X:  state_nx = mm.mm_ready ? ACC_X : WAIT_X;
            ACC_X:   state_nx = last ? START_H : ACC_X;
            START_H: state_nx = mm.mm_ready ? WAIT_H : START_H;
            WAIT_H:  state_nx = mm.mm_ready ? ACC_H : WAIT_H;
            ACC_H:   state_nx = last ? DONE : ACC_H;
            default: state_nx = IDLE;
        endcase
    end

    // Read-out index, accumulator capture and hidden-state update; sel wraps to 0 after each pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
            for (int i = 0; i < M; i++) begin
                acc[i] <= '0;
                h[i]   <= '0;
            end
        end else begin
            if (state == IDLE && clear_h)
                for (int i = 0; i < M; i++) h[i] <= '0;
            if (state == ACC_X || state == ACC_H) sel <= sel + 1'b1;
            if (state == ACC_X) acc[sel] <= mm.mm_data;
            if (state == ACC_H) h[sel] <= h_new;
        end
    end

    // Hidden-state read port; indices past the hidden length read as zero padding
    always_comb begin
        h_rd_data = (rd_ext >> HID_BITS) == '0 ? h[rd_ext[HID_BITS-1:0]] : 16'h0000;
    end

endmodule

// File: tb/tb_rnn_step_ctrl.sv
// tb_rnn_step_ctrl: directed vector bench with a behavioural matmul model
module tb_rnn_step_ctrl;

    localparam int N = 4;
    localparam int M = 4;
    localparam int K = N * M;

    typedef struct {
        logic        clr;
        logic [15:0] x0, xr, wx0, wxr, wh, bias, exp_h;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step_start = 1'b0;
    logic        clear_h = 1'b0;
    logic        busy, done;
    logic [1:0]  bias_sel;
    logic [15:0] bias_data;
    logic [1:0]  h_rd_sel;
    logic [15:0] h_rd_data;
    logic [1:0]  host_sel = 2'd0;

    logic [15:0] xv [N];
    logic [15:0] wx [M][N];
    logic [15:0] wh [M][N];
    logic [15:0] bias_mem [M];
    logic [15:0] hv [N];
    logic [15:0] res [M];

    int   cnt, pre;
    logic busy_q, src_q, new_phase, model_rd;
    logic stall_en = 1'b0;
    int   starts = 0, src_rises = 0, busy_cnt = 0;
    int   checks = 0, failures = 0;
    vec_t vecs [6];

    rnn_step_ctrl_if #(.HID_BITS(2)) mm_if ();

    rnn_step_ctrl #(.VEC_BITS(2), .HID_BITS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_start (step_start),
        .clear_h    (clear_h),
        .busy       (busy),
        .done       (done),
        .mm         (mm_if),
        .bias_sel   (bias_sel),
        .bias_data  (bias_data),
        .h_rd_sel   (h_rd_sel),
        .h_rd_data  (h_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dot(int i, logic src);
        logic signed [31:0] a;
        a = 0;
        for (int j = 0; j < N; j++)
            a += src ? $signed(wh[i][j]) * $signed(hv[j]) : $signed(wx[i][j]) * $signed(xv[j]);
        return a[23:8];
    endfunction

    assign model_rd       = cnt > 0 && mm_if.mm_src;
    assign h_rd_sel       = model_rd ? 2'(K + 1 - cnt) : host_sel;
    assign bias_data      = bias_mem[bias_sel];
    assign mm_if.mm_data  = res[mm_if.mm_sel];
    assign new_phase      = stall_en && ((busy && !busy_q) || (mm_if.mm_src && !src_q));
    assign mm_if.mm_ready = cnt == 0 && pre == 0 && !new_phase;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 0;
            pre    <= 0;
            busy_q <= 1'b0;
            src_q  <= 1'b0;
        end else begin
            busy_q <= busy;
            src_q  <= mm_if.mm_src;
            if (new_phase) pre <= 4;
            else if (pre > 0) pre <= pre - 1;
            if (mm_if.mm_start) cnt <= K + 1;
            else if (cnt > 0) cnt <= cnt - 1;
            if (model_rd && cnt > K + 1 - N) hv[K + 1 - cnt] <= h_rd_data;
            if (cnt == 1)
                for (int i = 0; i < M; i++) res[i] <= dot(i, mm_if.mm_src);
        end
    end

    always @(posedge clk) begin
        if (mm_if.mm_start) starts <= starts + 1;
        if (mm_if.mm_src && !src_q) src_rises <= src_rises + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_h(input logic [15:0] exp);
        for (int i = 0; i < M; i++) begin
            host_sel = 2'(i);
            #1;
            check($sformatf("h[%0d]", i), h_rd_data, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int j = 0; j < N; j++) xv[j] = j == 0 ? v.x0 : v.xr;
        for (int i = 0; i < M; i++) begin
            bias_mem[i] = v.bias;
            for (int j = 0; j < N; j++) begin
                wx[i][j] = j == 0 ? v.wx0 : v.wxr;
                wh[i][j] = v.wh;
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk) clear_h = 1'b1;
        @(negedge clk) clear_h = 1'b0;
    endtask

    task automatic run_step(output int lat);
        @(negedge clk) step_start = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 step_start = 1'b0;
        while (lat < 300) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, s0, r0, b0, t;
        vecs[0] = '{1'b1, 16'h0080, 16'h0080, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 47};
        vecs[1] = '{1'b0, 16'h0040, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 47};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 47};
        vecs[3] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFD00, 16'hFF00, 47};
        vecs[4] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF80, 16'hFF80, 47};
        vecs[5] = '{1'b0, 16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h01C0, 16'h0040, 47};
        load(vecs[0]);

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mm_start", mm_if.mm_start, 0);
        check("rst_mm_src", mm_if.mm_src, 0);
        check("rst_mm_sel", mm_if.mm_sel, 0);
        check_h(16'h0000);
        @(negedge clk) rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            load(vecs[v]);
            if (vecs[v].clr) do_clear();
            s0 = starts;
            run_step(lat);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("v%0d_starts", v), starts - s0, 2);
            @(negedge clk);
            check_h(vecs[v].exp_h);
        end

        load(vecs[0]);
        do_clear();
        stall_en = 1'b1;
        s0 = starts;
        r0 = src_rises;
        run_step(lat);
        check("stall_latency", lat, 57);
        check("stall_starts", starts - s0, 2);
        check("stall_src_rises", src_rises - r0, 1);
        @(negedge clk);
        stall_en = 1'b0;
        check_h(16'h0100);

        s0 = starts;
        b0 = busy_cnt;
        @(negedge clk) begin
            clear_h = 1'b1;
            step_start = 1'b1;
        end
        @(negedge clk) begin
            clear_h = 1'b0;
            step_start = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("prio_busy_cycles", busy_cnt - b0, 0);
        check("prio_starts", starts - s0, 0);
        check_h(16'h0000);

        load(vecs[0]);
        @(negedge clk) step_start = 1'b1;
        @(negedge clk) step_start = 1'b0;
        t = 0;
        while (!mm_if.mm_src && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach_h_pass", mm_if.mm_src, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_mm_start", mm_if.mm_start, 0);
        check("midrst_mm_src", mm_if.mm_src, 0);
        check("midrst_mm_sel", mm_if.mm_sel, 0);
        @(negedge clk) rst_n = 1'b1;
        check_h(16'h0000);
        run_step(lat);
        check("after_rst_latency", lat, 47);
        @(negedge clk);
        check_h(16'h0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rnn_step_ctrl.md
Name: rnn_step_ctrl

Overview:
- Sequences one RNN timestep, h_new = hardtanh(W_x*x + W_h*h + b), on a single shared matmul engine. The engine is a 16-bit Q8.8 matrix-vector multiplier with a start/ready handshake and a read-out select.
- Runs two multiply passes (input pass, then hidden pass), reads each result vector back, accumulates it with the bias, and clamps it.
- Holds the hidden-state vector between steps. Sits between the top-level host registers and the matmul instance.

Parameters:
VEC_BITS, 2, log2 of operand vector length; x and h are both padded to 2^VEC_BITS entries.
HID_BITS, 2, log2 of hidden/result length; this is the matmul column count.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
step_start  in  1  start one timestep; sampled in IDLE only
clear_h  in  1  zero the hidden state; sampled in IDLE only
busy  out  1  high from the cycle after step_start is accepted until DONE
done  out  1  one-cycle pulse when h is updated
mm_start  out  1  matmul start pulse
mm_ready  in  1  matmul ready
mm_src  out  1  operand mux select: 0 = x/W_x, 1 = h/W_h
mm_sel  out  HID_BITS  matmul result read select
mm_data  in  16  matmul result at mm_sel; combinational, valid when mm_ready=1
bias_sel  out  HID_BITS  bias memory select (equals mm_sel)
bias_data  in  16  signed Q8.8 bias at bias_sel; combinational
h_rd_sel  in  VEC_BITS  hidden-state read address, driven by matmul sel_vec or the host
h_rd_data  out  16  h[h_rd_sel]; combinational; entries at index >= 2^HID_BITS read 0

Behaviour:
- Reset: state IDLE. busy, done, mm_start, mm_src and mm_sel are all 0. Accumulator and h are cleared to 0. Reset mid-operation aborts the step with no partial h write visible afterwards; the matmul shares rst_n.
- States: IDLE, START_X, WAIT_X, ACC_X, START_H, WAIT_H, ACC_H, DONE.
- IDLE:
  - clear_h=1: zero h in one cycle and stay in IDLE. clear_h has priority; a simultaneous step_start is dropped.
  - Otherwise step_start=1: go to START_X.
  - Both inputs are ignored in every non-IDLE state.
- START_X / START_H:
  - mm_src is 0 in the X states and 1 in the H states; it is held stable through WAIT and ACC.
  - When mm_ready=1, assert mm_start for exactly one cycle, then go to WAIT_*.
  - When mm_ready=0, hold with mm_start=0.
- WAIT_*: wait for mm_ready=1. Ready is already low in the first WAIT cycle, so no masking is needed. mm_start stays 0.
- ACC_X: mm_sel counts 0 to 2^HID_BITS-1, one entry per cycle, writing acc[i] = mm_data. After the last entry, go to START_H with mm_sel=0.
- ACC_H:
  - Per entry: s = sext18(acc[i]) + sext18(mm_data) + sext18(bias_data).
  - h[i] = clamp(s, -256, +256), i.e. ±1.0 in Q8.8.
  - After the last entry, go to DONE.
- Write timing: h writes take effect at the clock edge. The matmul reads h only in WAIT_H, so there is no read/write overlap.
- DONE: done=1 for one cycle, then IDLE. busy drops in that same IDLE cycle.
- Latency: with K = 2^(VEC_BITS+HID_BITS) and M = 2^HID_BITS, and mm_ready responding at nominal matmul timing, done asserts 2*(K+M+3)+1 cycles after the step_start cycle. This is 47 cycles at the defaults. Extra mm_ready stall cycles add one-for-one.
- Wrap-around: mm_sel wraps to 0 after the last entry. h_rd_sel beyond the hidden length returns 0, which implements zero padding.

Decomposition:
- Package rnn_pkg: the state enum, FRAC_BITS=8, Q_ONE=16'sh0100, Q_NEG_ONE=16'shFF00.
- One sub-module, q88_hardtanh: combinational 18-bit in, clamped 16-bit out. It is reused by later activation blocks.
- Storage for acc and h is internal arrays, not tensor_1d, because h needs a separate read address and write index.

Test Plan:
All scenarios use defaults, bias 0 and a behavioural matmul model unless stated.
- Saturation: clear_h; x = 4x0x0080, W_x all 0x0100, W_h all 0, step -> every h = 0x0100 (raw 0x0200 clamped); done 47 cycles after step_start.
- Two-step recurrence: x = [0x0040,0,0,0], W_x row0 = 0x0100, W_h = 0, step -> all h = 0x0040. Then x = 0, W_h all 0x0100, step -> all h = 0x0100.
- Negative clamp: x = 0, h = 0, bias all 0xFD00 -> all h = 0xFF00. With bias all 0xFF80 -> all h = 0xFF80.
- Handshake stall: model holds mm_ready low 5 extra cycles before each pass -> exactly two mm_start pulses; done delayed by 10 cycles; mm_src toggles only at START_H.
- IDLE priority: clear_h and step_start together with h nonzero -> h all 0; busy stays 0; no mm_start.
- Reset mid WAIT_H: assert rst_n low for 1 cycle -> all outputs 0, h reads 0. A fresh step then completes normally with the scenario-1 results.
